fft_twiddle_seq: RTL and testbench

Parametrised stage sequencer and twiddle generator for a radix-2 single-path delay-feedback (SDF) FFT pipeline. One instance sits beside each butterfly stage. It counts valid samples and reports the stage phase (fill / butterfly / twiddle-multiply) on `state`. During the twiddle phase it supplies the fixed-point twiddle factor W_N^k = exp(-j2πk/N), derived from a quarter-wave cosine table. It generalises the fixed 4-point twiddle ROM to any FFT length, stage index and word width, and adds an automatic flush after input ends.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/twiddle_qwave_lut.sv | 46 ++++
 rtl/fft_twiddle_seq.sv | 118 +++++++++++
 tb/tb_fft_twiddle_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and elaboration helpers for the SDF FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BFLY,
    TWID
  } sdf_state_t;

  localparam logic [1:0] STATE_FILL = 2'd0;
  localparam logic [1:0] STATE_BFLY = 2'd1;
  localparam logic [1:0] STATE_TWID = 2'd2;

  // round(cos(2*pi*m/N) * 2^frac), half away from zero
  function automatic int cos_q(
    input int m,
    input int log2n,
    input int frac
  );
    real n;
    real s;
    real x;
    n = real'(1 << log2n);
    s = real'(1 << frac);
    x = $cos(2.0 * 3.14159265358979323846 * real'(m) / n) * s;
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/twiddle_qwave_lut.sv
// Twiddle factor W_N^k from a quarter-wave cosine table and quadrant fold.
module twiddle_qwave_lut
  import fft_pkg::*;
#(
  parameter int LOG2N = 6,
  parameter int DW    = 24,
  parameter int FRAC  = 8
) (
  input  logic        [LOG2N-2:0] idx,
  output logic signed [DW-1:0]    w_r,
  output logic signed [DW-1:0]    w_i
);

  localparam int IW = LOG2N - 1;
  localparam int Q  = 1 << (LOG2N - 2);

  logic signed [DW-1:0] c_tab [0:Q];

  for (genvar m = 0; m <= Q; m++) begin : g_c
    localparam int CV = cos_q(m, LOG2N, FRAC);
    assign c_tab[m] = DW'(CV);
  end

  logic [IW-1:0] a;
  logic [IW-1:0] b;

  // second quadrant: N/2-k taken modulo 2^IW
  always_comb begin
    a   = '0;
    b   = '0;
    w_r = '0;
    w_i = '0;
    if (idx <= IW'(Q)) begin
      a   = idx;
      b   = IW'(Q) - idx;
      w_r = c_tab[a];
      w_i = -c_tab[b];
    end else begin
      a   = IW'(0) - idx;
      b   = idx - IW'(Q);
      w_r = -c_tab[a];
      w_i = -c_tab[b];
    end
  end

endmodule

// File: rtl/fft_twiddle_seq.sv
// SDF radix-2 stage sequencer: fill/butterfly/twiddle phases plus auto flush.
module fft_twiddle_seq
  import fft_pkg::*;
#(
  parameter int LOG2N = 6,
  parameter int STAGE = 4,
  parameter int DW    = 24,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic        [1:0]    state,
  output logic signed [DW-1:0] w_r,
  output logic signed [DW-1:0] w_i,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int D  = 1 << (LOG2N - STAGE - 1);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int FW = $clog2(D) + 1;
  localparam int IW = LOG2N - 1;

  localparam logic signed [DW-1:0] ONE = DW'(1) << FRAC;

  sdf_state_t    st_q, st_d;
  logic [PW-1:0] p_q, p_d;
  logic [FW-1:0] f_q, f_d;
  logic          adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      p_q  <= '0;
      f_q  <= '0;
    end else begin
      st_q <= st_d;
      p_q  <= p_d;
      f_q  <= f_d;
    end
  end

  always_comb begin
    st_d = st_q;
    p_d  = p_q;
    f_d  = f_q;
    adv  = in_valid | (f_q != '0);
    if (in_valid) begin
      f_d = '0;
    end else if (st_q != IDLE && f_q == '0) begin
      f_d = FW'(D);
    end else if (f_q != '0) begin
      f_d = f_q - FW'(1);
    end
    if (adv) begin
      unique case (st_q)
        IDLE: begin
          if (D == 1) begin
            st_d = BFLY;
            p_d  = '0;
          end else begin
            st_d = FILL;
            p_d  = PW'(1);
          end
        end
        default: begin
          if (p_q == PW'(D - 1)) begin
            p_d  = '0;
            st_d = (st_q == BFLY) ? TWID : BFLY;
          end else begin
            p_d = p_q + PW'(1);
          end
        end
      endcase
      // last flush advance drops back to idle
      if (!in_valid && f_q == FW'(1)) begin
        st_d = IDLE;
        p_d  = '0;
      end
    end
  end

  logic        [IW-1:0] k;
  logic signed [DW-1:0] lut_r;
  logic signed [DW-1:0] lut_i;

  assign k = IW'(p_q) << STAGE;

  twiddle_qwave_lut #(
    .LOG2N(LOG2N),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_lut (
    .idx(k),
    .w_r(lut_r),
    .w_i(lut_i)
  );

  always_comb begin
    state = STATE_FILL;
    w_r   = ONE;
    w_i   = '0;
    unique case (st_q)
      BFLY: state = STATE_BFLY;
      TWID: begin
        state = STATE_TWID;
        w_r   = lut_r;
        w_i   = lut_i;
      end
      default: ;
    endcase
  end

  assign out_valid = adv & (st_q == BFLY || st_q == TWID);
  assign busy      = (st_q != IDLE);

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Scoreboard bench: three stage configs against a position-based reference.
module tb_fft_twiddle_seq;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NI-1:0]   iv;
  logic [1:0]      st [NI];
  logic [23:0]     wr [NI];
  logic [23:0]     wi [NI];
  logic            ov [NI];
  logic            bz [NI];

  always #5 clk = ~clk;

  fft_twiddle_seq #(.LOG2N(6), .STAGE(4), .DW(24), .FRAC(8)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .state(st[0]),
    .w_r(wr[0]), .w_i(wi[0]), .out_valid(ov[0]), .busy(bz[0])
  );
  fft_twiddle_seq #(.LOG2N(3), .STAGE(0), .DW(24), .FRAC(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .state(st[1]),
    .w_r(wr[1]), .w_i(wi[1]), .out_valid(ov[1]), .busy(bz[1])
  );
  fft_twiddle_seq #(.LOG2N(6), .STAGE(5), .DW(24), .FRAC(8)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .state(st[2]),
    .w_r(wr[2]), .w_i(wi[2]), .out_valid(ov[2]), .busy(bz[2])
  );

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic [23:0] wr;
    logic [23:0] wi;
    logic       ov;
    logic       bz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference: pos = advances since leaving idle; segment pos/D picks phase
  int pos [NI];
  int fc  [NI];
  bit act [NI];

  function automatic int lg(input int i);
    return (i == 1) ? 3 : 6;
  endfunction

  function automatic int sg(input int i);
    return (i == 0) ? 4 : (i == 1) ? 0 : 5;
  endfunction

  function automatic int dd(input int i);
    return 1 << (lg(i) - sg(i) - 1);
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic exp_t exp_of(input int i, input bit v);
    exp_t e;
    int   seg;
    int   k;
    real  th;
    e.idx = i;
    e.st  = 2'd0;
    e.wr  = 24'd256;
    e.wi  = 24'd0;
    e.ov  = 1'b0;
    e.bz  = act[i];
    if (act[i]) begin
      seg = pos[i] / dd(i);
      if (seg > 0) begin
        e.st = (seg % 2 == 1) ? 2'd1 : 2'd2;
        e.ov = v || (fc[i] != 0);
      end
      if (e.st == 2'd2) begin
        k    = (pos[i] % dd(i)) * (1 << sg(i));
        th   = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << lg(i));
        e.wr = 24'(rnd($cos(th) * 256.0));
        e.wi = 24'(rnd(-$sin(th) * 256.0));
      end
    end
    return e;
  endfunction

  function automatic void model_adv(input int i, input bit v);
    if (v) begin
      fc[i]  = 0;
      act[i] = 1'b1;
      pos[i] = pos[i] + 1;
    end else if (act[i] && fc[i] == 0) begin
      fc[i] = dd(i);
    end else if (fc[i] != 0) begin
      fc[i]  = fc[i] - 1;
      pos[i] = pos[i] + 1;
      if (fc[i] == 0) begin
        act[i] = 1'b0;
        pos[i] = 0;
      end
    end
  endfunction

  task automatic step(input logic [NI-1:0] v, input bit rst);
    reset = rst;
    iv    = v;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        act[i] = 1'b0;
        pos[i] = 0;
        fc[i]  = 0;
      end
    end
    for (int i = 0; i < NI; i++) sb.push_back(exp_of(i, v[i]));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NI; i++) model_adv(i, v[i]);
    end
    #1;
  endtask

  task automatic run(input logic [NI-1:0] v, input int n);
    for (int c = 0; c < n; c++) step(v, 1'b0);
  endtask

  exp_t m;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m = sb.pop_front();
      checks++;
      if (st[m.idx] !== m.st || wr[m.idx] !== m.wr ||
          wi[m.idx] !== m.wi || ov[m.idx] !== m.ov ||
          bz[m.idx] !== m.bz) begin
        errors++;
        $display("FAIL dut%0d t=%0t got st=%0d wr=%0d wi=%0d ov=%0b bz=%0b want st=%0d wr=%0d wi=%0d ov=%0b bz=%0b",
                 m.idx, $time, st[m.idx], $signed(wr[m.idx]),
                 $signed(wi[m.idx]), ov[m.idx], bz[m.idx], m.st,
                 $signed(m.wr), $signed(m.wi), m.ov, m.bz);
      end
    end
  end

  logic [NI-1:0] rv;

  initial begin
    reset = 1'b1;
    iv    = '0;
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0;
      pos[i] = 0;
      fc[i]  = 0;
    end
    @(posedge clk);
    #1;
    step('0, 1'b1);
    step('0, 1'b1);
    run('0, 3);
    run('1, 24);
    run('0, 8);
    step('0, 1'b1);
    run('1, 7);
    run('0, 6);
    run('1, 7);
    run('0, 1);
    run('1, 10);
    step('0, 1'b1);
    run('1, 9);
    step('1, 1'b1);
    run('1, 12);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        step('0, 1'b1);
      end else if ($urandom_range(0, 19) == 0) begin
        run('0, $urandom_range(1, 7));
      end else begin
        for (int i = 0; i < NI; i++) rv[i] = ($urandom_range(0, 3) != 0);
        step(rv, 1'b0);
      end
    end
    run('0, 8);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
